// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Request/result bundle for the bit-serial adder.
//  Ports    : master - drives start, a, b, cin, sub; observes busy, done,
//                      sum, cout
//             slave  - the adder side of the same signals
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout
   );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder. One full-adder cell and a carry
//             flip-flop process the operands LSB-first, one bit per clock.
//             A start pulse in IDLE or DONE loads a, b, cin; after WIDTH
//             RUN cycles the sum and carry-out are registered and done
//             strobes for one cycle.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - serial_adder_if.slave (start, a, b, cin, sub in;
//                     busy, done, sum, cout out)
//  Macro    : SERIAL_ADDER_SUB_EN - when defined, sub=1 selects A - B - cin
//             with cout as the final borrow. When undefined, sub is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [WIDTH-1:0]   ra;
   logic [WIDTH-1:0]   rb;
   logic [WIDTH-1:0]   rs;
   logic               c;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sum_reg;
   logic               cout_reg;

   logic               bit_s;
   logic               carry_add;
   logic               carry_next;
   logic               last;
   logic               accept;

`ifdef SERIAL_ADDER_SUB_EN
   logic               mode;
   logic               borrow_next;
`else
   logic               unused_sub;
   assign unused_sub = bus.sub;
`endif

   assign last   = (cnt == LAST_BIT);
   assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

   // --------------------------------------------------------------------
   // Single-bit cell. Sum and difference share the same XOR; only the
   // carry/borrow term depends on the mode.
   // --------------------------------------------------------------------
   always_comb begin
      bit_s      = ra[0] ^ rb[0] ^ c;
      carry_add  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
      carry_next = carry_add;
`ifdef SERIAL_ADDER_SUB_EN
      borrow_next = (~ra[0] & c) | (rb[0] & c) | (~ra[0] & rb[0]);
      if (mode) begin
         carry_next = borrow_next;
      end
`endif
   end

   // --------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start) state_next = S_RUN;
         S_RUN:   if (last)      state_next = S_DONE;
         S_DONE:  state_next = bus.start ? S_RUN : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------
   // Datapath
   // --------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra       <= '0;
         rb       <= '0;
         rs       <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         mode     <= 1'b0;
`endif
      end else if (accept) begin
         ra  <= bus.a;
         rb  <= bus.b;
         c   <= bus.cin;
         cnt <= '0;
         rs  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         mode <= bus.sub;
`endif
      end else if (state == S_RUN) begin
         c   <= carry_next;
         // Result bits enter at the MSB; after WIDTH shifts the first
         // (least significant) bit has arrived at rs[0].
         rs  <= {bit_s, rs[WIDTH-1:1]};
         ra  <= ra >> 1;
         rb  <= rb >> 1;
         cnt <= cnt + CNT_W'(1);
         if (last) begin
            sum_reg  <= {bit_s, rs[WIDTH-1:1]};
            cout_reg <= carry_next;
         end
      end
   end

   assign bus.busy = (state == S_RUN);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed-vector bench for serial_adder (WIDTH=8). Stimulus
//             pushes expected results into a queue; a negedge monitor pops
//             and compares each time done is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      int               due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_done = 0;
   exp_t q[$];

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done strobe must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done === 1'b1) begin
         n_done++;
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("sum", 32'(bus.sum), 32'(e.sum));
            check("cout", 32'(bus.cout), 32'(e.cout));
            check("done_latency", cyc, e.due);
         end
      end
   end

   // Presents a request and returns just after the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] es, input logic ec);
      exp_t e;
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
      @(posedge clk); #1;
      e.sum = es; e.cout = ec; e.due = cyc + WIDTH;
      q.push_back(e);
      bus.start = 1'b0;
      bus.a = ~a; bus.b = ~b; bus.cin = ~cin; bus.sub = ~sub;
   endtask

   // Waits (bounded) for done; returns at the negedge of the DONE cycle.
   task automatic wait_done(input logic [WIDTH-1:0] hold, output int busy_cnt, output int done_cyc);
      bit held = 1'b1;
      bit seen = 1'b0;
      busy_cnt = 0;
      done_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            done_cyc = cyc;
            break;
         end
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.sum !== hold) held = 1'b0;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("sum_hold", 32'(held), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int bc, d1, d2, nd;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_sum",  32'(bus.sum),  32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic add, busy span and hold of the previous (reset) result.
      issue(8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0);
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      wait_done(8'h00, bc, d1);
      check("busy_cycles", bc, WIDTH);

      // Wrap-around with carry out, then carry-in propagation.
      @(posedge clk); #1;
      check("idle_after_done", 32'(bus.busy | bus.done), 32'd0);
      issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      wait_done(8'h61, bc, d1);
      @(posedge clk); #1;
      issue(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);
      wait_done(8'h00, bc, d1);

      // Start during RUN cycle 3 is ignored.
      @(posedge clk); #1;
      nd = n_done;
      issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(8'h80, bc, d1);
      repeat (4) @(posedge clk);
      #1;
      check("single_done", n_done - nd, 1);

      // Back-to-back: start presented during DONE.
      issue(8'h05, 8'h06, 1'b0, 1'b0, 8'h0B, 1'b0);
      wait_done(8'h02, bc, d1);
      issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done(8'h0B, bc, d2);
      check("b2b_spacing", d2 - d1, WIDTH + 1);

      // Reset in RUN cycle 4 discards the operation.
      @(posedge clk); #1;
      issue(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      void'(q.pop_back());
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_sum",  32'(bus.sum),  32'd0);
      check("midrst_cout", 32'(bus.cout), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      nd = n_done;
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_rst", n_done - nd, 0);
      issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
      wait_done(8'h00, bc, d1);

`ifdef SERIAL_ADDER_SUB_EN
      @(posedge clk); #1;
      issue(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
      wait_done(8'h46, bc, d1);
      @(posedge clk); #1;
      issue(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
      wait_done(8'h0F, bc, d1);
      @(posedge clk); #1;
      issue(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1);
      wait_done(8'hFF, bc, d1);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: one full-adder cell plus a carry flip-flop, processing operands LSB-first, one bit per clock.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done strobe.
- Area-cheap arithmetic engine for the combinational adder/subtractor cells in the design; serves as the adder counterpart to the existing full-subtractor logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request pulse; accepted only in IDLE or DONE
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in (borrow-in in subtract mode), sampled on the accepting edge
- sub  input  1  mode select, sampled on the accepting edge; used only when SERIAL_ADDER_SUB_EN is defined
- busy  output  1  high while in RUN
- done  output  1  one-cycle strobe; sum/cout are valid from this cycle on
- sum  output  WIDTH  result register
- cout  output  1  final carry-out (borrow-out in subtract mode)

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - internal shift registers, carry flip-flop and bit counter = 0
- FSM states: IDLE, RUN, DONE. Outputs are registered or decoded from state only:
  - busy = (state == RUN)
  - done = (state == DONE)
- IDLE:
  - start=1 → load ra<=a, rb<=b, c<=cin, mode<=sub, cnt<=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, on each edge:
  - Add mode: s = ra[0]^rb[0]^c; c <= (ra[0]&rb[0]) | (ra[0]&c) | (rb[0]&c).
  - Shift s into the MSB of the internal result shift register rs.
  - ra and rb shift right by one; cnt <= cnt+1.
  - When cnt == WIDTH-1 on this edge:
    - sum <= final rs value, including this bit.
    - cout <= next carry.
    - Go to DONE.
- RUN timing:
  - Exactly WIDTH edges are spent in RUN.
  - done is high during the cycle following the WIDTH-th RUN edge.
  - Latency from the start-accepting edge to done high: WIDTH edges.
- DONE:
  - Lasts exactly one cycle.
  - start=1 → accepted exactly as in IDLE (back-to-back operation); go to RUN.
  - Otherwise → IDLE.
- Throughput: one result per WIDTH+1 cycles.
- sum and cout change only on the edge entering DONE. They hold through IDLE and through the following RUN until the next completion.
- start while busy is ignored: no reload, and operands are unaffected by input changes.
- a, b, cin and sub may change freely after the accepting edge.
- rst_n asserted mid-RUN: immediate return to the reset values; any partial result is discarded.
- Arithmetic is modulo 2^WIDTH; overflow is visible only through cout.
- cnt width: clog2(WIDTH), sized to reach WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - mode=1 selects subtraction A - B - cin, with the per-bit cell:
    - diff = ra[0]^rb[0]^c
    - borrow_next = (~ra[0]&c) | (rb[0]&c) | (~ra[0]&rb[0])
  - sum holds the difference and cout holds the final borrow (1 when A < B + cin).
  - mode=0 adds as normal.
- Undefined:
  - The sub port remains present but is ignored.
  - The mode register and borrow logic are not synthesized; the block always adds.

Test Plan (WIDTH=8):
- Reset, then a=8'h3C, b=8'h25, cin=0, start pulse:
  - busy high for 8 cycles.
  - done strobes 8 edges after acceptance.
  - sum=8'h61, cout=0; sum is unchanged while busy.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'h7F, b=8'h00, cin=1 → sum=8'h80, cout=0.
- Issue a start with a=8'h01, b=8'h01. Pulse start again at RUN cycle 3 with a=8'hAA, b=8'h55:
  - second request ignored.
  - result sum=8'h02, cout=0.
  - exactly one done strobe.
- start held high across DONE with new operands a=8'h10, b=8'h20:
  - second operation begins immediately (no IDLE cycle).
  - second done at 9-cycle spacing; sum=8'h30.
- rst_n pulsed low at RUN cycle 4:
  - busy, done, sum, cout all 0 immediately.
  - no done afterwards.
  - a new start afterwards completes correctly.
- With SERIAL_ADDER_SUB_EN defined, sub=1:
  - 8'h10 - 8'h01, cin=0 → sum=8'h0F, cout=0.
  - 8'h00 - 8'h01, cin=0 → sum=8'hFF, cout=1.
  - 8'h05 - 8'h05, cin=1 → sum=8'hFF, cout=1.
